// File: rtl/fft_frame_sched_if.sv
// ---------------------------------------------------------------------------
// fft_frame_sched_if
//   Groups the data-path handshakes of the FFT frame scheduler: the sample
//   input stream, the loader RAM write port, the FFT core start/ready pair
//   with the RAM ownership select, and the unloader read/result stream.
//
//   Parameter
//     N_LOG2     log2 of the frame length; the bank select is 2 bits and
//                the per-bank address is N_LOG2-2 bits.
//
//   Modports
//     master     the scheduler (drives every o* signal)
//     slave      the environment: sample source, RAM, core, sink
//                (drives every i* signal)
// ---------------------------------------------------------------------------
interface fft_frame_sched_if #(
  parameter int N_LOG2 = 11
);
  localparam int AW = N_LOG2 - 2;

  // Sample input stream and loader write port
  logic          iIN_VALID;
  logic          oIN_READY;
  logic [1:0]    oWR_BANK;
  logic [AW-1:0] oWR_ADDR;
  logic          oWR_EN;

  // FFT core control and RAM port ownership
  logic          oFFT_START;
  logic          iFFT_RDY;
  logic [1:0]    oRAM_OWNER;

  // Unloader read port and result stream
  logic          iOUT_REQ;
  logic [1:0]    oRD_BANK;
  logic [AW-1:0] oRD_ADDR;
  logic          oRD_EN;
  logic          oOUT_VALID;
  logic          oOUT_LAST;

  modport master (
    input  iIN_VALID, iFFT_RDY, iOUT_REQ,
    output oIN_READY, oWR_BANK, oWR_ADDR, oWR_EN,
           oFFT_START, oRAM_OWNER,
           oRD_BANK, oRD_ADDR, oRD_EN, oOUT_VALID, oOUT_LAST
  );

  modport slave (
    output iIN_VALID, iFFT_RDY, iOUT_REQ,
    input  oIN_READY, oWR_BANK, oWR_ADDR, oWR_EN,
           oFFT_START, oRAM_OWNER,
           oRD_BANK, oRD_ADDR, oRD_EN, oOUT_VALID, oOUT_LAST
  );
endinterface

// File: rtl/fft_frame_sched.sv
// ---------------------------------------------------------------------------
// fft_frame_sched
//   Frame-level scheduler for the banked radix-4 FFT core. Each frame runs
//   LOAD (accept 2**N_LOG2 samples into the banks), RUN (one start pulse to
//   the core controller, then wait for ready to drop and rise again, under a
//   watchdog) and UNLOAD (stream the results back out on request). The block
//   owns the RAM port select so loader, core and unloader never overlap.
//
//   Ports
//     iCLK        clock
//     iRESET      asynchronous active-low reset
//     iENABLE     allows a new frame to begin from IDLE
//     iABORT      synchronous abort back to IDLE, highest priority
//     bus         fft_frame_sched_if.master (streams, RAM ports, core ctl)
//     oBUSY       high whenever the scheduler is not IDLE
//     oERR        sticky watchdog flag, cleared only by reset
//     oFRAME_CNT  completed frames, wraps
// ---------------------------------------------------------------------------
module fft_frame_sched #(
  parameter int N_LOG2  = 11,
  parameter int TIMEOUT = 8192,
  parameter int FCNT_W  = 16
) (
  input  logic                  iCLK,
  input  logic                  iRESET,
  input  logic                  iENABLE,
  input  logic                  iABORT,
  fft_frame_sched_if.master     bus,
  output logic                  oBUSY,
  output logic                  oERR,
  output logic [FCNT_W-1:0]     oFRAME_CNT
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  localparam logic [N_LOG2-1:0] IDX_LAST = '1;
  localparam logic [N_LOG2-1:0] IDX_ONE  = N_LOG2'(1);
  localparam logic [WD_W-1:0]   WD_ONE   = WD_W'(1);
  localparam logic [WD_W-1:0]   WD_LIMIT = WD_W'(TIMEOUT - 1);
  localparam logic [FCNT_W-1:0] FCNT_ONE = FCNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT_LO,
    S_WAIT_HI,
    S_UNLOAD,
    S_DRAIN
  } state_e;

  typedef enum logic [1:0] {
    OWN_LOADER   = 2'd0,
    OWN_FFT      = 2'd1,
    OWN_UNLOADER = 2'd2,
    OWN_NONE     = 2'd3
  } owner_e;

  state_e              state_q, state_d;
  logic [N_LOG2-1:0]   idx_q, idx_d;          // sample index for load/unload
  logic [N_LOG2-1:0]   rd_idx_q, rd_idx_d;    // index of the read in flight
  logic                rd_en_q, rd_en_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic [WD_W-1:0]     wdog_q, wdog_d;
  logic                err_q, err_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;

  logic                transfer;
  logic                rd_req;
  logic                wd_expired;
  owner_e              owner;

  assign transfer   = (state_q == S_LOAD)   && bus.iIN_VALID;
  assign rd_req     = (state_q == S_UNLOAD) && bus.iOUT_REQ;
  assign wd_expired = (wdog_q == WD_LIMIT);

  // NOTE: every variable assigned in an always_comb gets a default first, so
  // no path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wdog_d      = wdog_q;
    err_d       = err_q;
    fcnt_d      = fcnt_q;
    // Read pipeline: a request is issued as a registered read on the next
    // edge, and the RAM data is flagged valid one cycle after that.
    rd_en_d     = rd_req;
    rd_idx_d    = rd_req ? idx_q : rd_idx_q;
    out_valid_d = rd_en_q;
    out_last_d  = rd_en_q && (rd_idx_q == IDX_LAST);

    unique case (state_q)
      S_IDLE: begin
        if (iENABLE && bus.iFFT_RDY) begin
          state_d = S_LOAD;
          idx_d   = '0;
        end
      end
      S_LOAD: begin
        if (transfer) begin
          idx_d = idx_q + IDX_ONE;
          if (idx_q == IDX_LAST) state_d = S_START;
        end
      end
      S_START: begin
        wdog_d  = '0;
        state_d = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        wdog_d = wdog_q + WD_ONE;
        if (wd_expired) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (!bus.iFFT_RDY) begin
          state_d = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        wdog_d = wdog_q + WD_ONE;
        if (wd_expired) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (bus.iFFT_RDY) begin
          state_d = S_UNLOAD;
          idx_d   = '0;
        end
      end
      S_UNLOAD: begin
        if (rd_req) begin
          idx_d = idx_q + IDX_ONE;
          if (idx_q == IDX_LAST) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        fcnt_d  = fcnt_q + FCNT_ONE;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over every transition. Both read-pipeline stages are
    // flushed: the pending result is dropped, and no read can issue after
    // ownership has already been released in IDLE.
    if (iABORT) begin
      state_d     = S_IDLE;
      idx_d       = '0;
      fcnt_d      = fcnt_q;
      rd_en_d     = 1'b0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      rd_idx_q    <= '0;
      rd_en_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      wdog_q      <= '0;
      err_q       <= 1'b0;
      fcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rd_idx_q    <= rd_idx_d;
      rd_en_q     <= rd_en_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      wdog_q      <= wdog_d;
      err_q       <= err_d;
      fcnt_q      <= fcnt_d;
    end
  end

  // Ownership is a pure function of the registered state, so it only changes
  // on state-entry edges and always covers the strobe issued in that state.
  always_comb begin
    owner = OWN_NONE;
    unique case (state_q)
      S_LOAD:                         owner = OWN_LOADER;
      S_START, S_WAIT_LO, S_WAIT_HI:  owner = OWN_FFT;
      S_UNLOAD, S_DRAIN:              owner = OWN_UNLOADER;
      default:                        owner = OWN_NONE;
    endcase
  end

  assign bus.oIN_READY  = (state_q == S_LOAD);
  assign bus.oWR_EN     = transfer;
  assign bus.oWR_BANK   = idx_q[N_LOG2-1:N_LOG2-2];
  assign bus.oWR_ADDR   = idx_q[N_LOG2-3:0];

  assign bus.oFFT_START = (state_q == S_START);
  assign bus.oRAM_OWNER = owner;

  assign bus.oRD_EN     = rd_en_q;
  assign bus.oRD_BANK   = rd_idx_q[N_LOG2-1:N_LOG2-2];
  assign bus.oRD_ADDR   = rd_idx_q[N_LOG2-3:0];
  assign bus.oOUT_VALID = out_valid_q;
  assign bus.oOUT_LAST  = out_last_q;

  assign oBUSY      = (state_q != S_IDLE);
  assign oERR       = err_q;
  assign oFRAME_CNT = fcnt_q;

endmodule
